// File: rtl/pair_xor_fold_pipe.sv
// pair_xor_fold_pipe
//   Pipelined pairwise XOR compressor. Each of NCH channels carries an IN_W-bit word. The word
//   is folded LEVELS times: each level XORs adjacent bit pairs and registers the result. Folded
//   words either pass straight through or are XOR-accumulated over a multi-beat window closed by
//   in_last. Valid/ready handshakes on both sides; empty stages accept even when the output stalls.
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready is combinational from downstream only
//   in_data              channel c = in_data[c*IN_W +: IN_W]
//   in_acc, in_last      beat joins the accumulation window / closes it (in_last ignored if !in_acc)
//   out_valid/out_ready  output handshake; out_data/out_beats are held while stalled
//   out_data             channel c = out_data[c*OUT_W +: OUT_W], OUT_W = IN_W >> LEVELS
//   out_beats            number of input beats combined into out_data (saturating)
module pair_xor_fold_pipe #(
    parameter int unsigned IN_W   = 128,
    parameter int unsigned NCH    = 2,
    parameter int unsigned LEVELS = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NCH*IN_W-1:0]               in_data,
    input  logic                              in_acc,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NCH*(IN_W>>LEVELS)-1:0]     out_data,
    output logic [CNT_W-1:0]                  out_beats
);

    localparam int unsigned OUT_W = IN_W >> LEVELS;

    // Bit offset of the level-k word inside the packed chain of all stage outputs.
    function automatic int unsigned lvl_off(input int unsigned k);
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < k; i++) s += NCH * (IN_W >> i);
        return s;
    endfunction

    localparam int unsigned CHAIN_W = lvl_off(LEVELS + 1);
    localparam int unsigned OFF_L   = lvl_off(LEVELS);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    // Level 0 of each bus is the input port; level k is the register of stage k.
    logic [CHAIN_W-1:0] chain;
    logic [LEVELS:0]    vv, aa, ll;
    logic [LEVELS:1]    adv, load;
    logic               out_free;

    assign chain[NCH*IN_W-1:0] = in_data;
    assign vv[0] = in_valid;
    assign aa[0] = in_acc;
    assign ll[0] = in_last;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
        localparam int unsigned WI    = IN_W >> (k - 1);
        localparam int unsigned WO    = IN_W >> k;
        localparam int unsigned OFF_I = lvl_off(k - 1);
        localparam int unsigned OFF_O = lvl_off(k);

        logic [NCH*WI-1:0] din;
        logic [NCH*WO-1:0] fold, data_q;
        logic              valid_q, acc_q, last_q;

        assign din = chain[OFF_I +: NCH*WI];

        always_comb begin
            fold = '0;
            for (int c = 0; c < int'(NCH); c++) begin
                for (int j = 0; j < int'(WO); j++) begin
                    fold[c*WO+j] = din[c*WI+2*j] ^ din[c*WI+2*j+1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                acc_q   <= 1'b0;
                last_q  <= 1'b0;
                data_q  <= '0;
            end else if (load[k]) begin
                valid_q <= vv[k-1];
                if (vv[k-1]) begin
                    data_q <= fold;
                    acc_q  <= aa[k-1];
                    last_q <= ll[k-1];
                end
            end
        end

        assign chain[OFF_O +: NCH*WO] = data_q;
        assign vv[k] = valid_q;
        assign aa[k] = acc_q;
        assign ll[k] = last_q;
    end

    // ACC / output stage state
    state_e                 state_q, state_d;
    logic [NCH*OUT_W-1:0]   acc_q, acc_d, acc_base, folded;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   out_valid_q, out_valid_d;
    logic [NCH*OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_beats_q, out_beats_d;

    assign folded = chain[OFF_L +: NCH*OUT_W];

    // Advance chain: the last stage drains into ACC when its beat can be consumed; earlier
    // stages advance when the next one is empty or itself advancing (bubbles collapse).
    always_comb begin
        adv      = '0;
        out_free = !out_valid_q || out_ready;
        adv[LEVELS] = vv[LEVELS] && ((aa[LEVELS] && !ll[LEVELS]) || out_free);
        for (int k = int'(LEVELS) - 1; k >= 1; k--) begin
            adv[k] = vv[k] && (!vv[k+1] || adv[k+1]);
        end
        load = ~vv[LEVELS:1] | adv;
    end

    assign in_ready = !rst && load[1];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        acc_base    = (state_q == StAccum) ? acc_q : '0;
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (vv[LEVELS]) begin
            if (!aa[LEVELS]) begin
                // Pass-through: leaves any open window untouched.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = folded;
                    out_beats_d = CNT_W'(1);
                end
            end else if (!ll[LEVELS]) begin
                // Absorbed even while the output register is stalled.
                acc_d   = acc_base ^ folded;
                cnt_d   = cnt_inc;
                state_d = StAccum;
            end else if (out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_base ^ folded;
                out_beats_d = cnt_inc;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

endmodule
